// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART message controller and anything that talks to it.
// Holds the packet geometry, header codes, payload field positions, reply bytes,
// the controller state encoding and the configuration record.
package uart_msg_pkg;

    localparam int MSG_W   = 40;   // header byte + 32-bit payload
    localparam int MSG_BYTES = 5;  // bytes per packet, LSB first on the wire
    localparam int HDR_W   = 8;
    localparam int PL_W    = MSG_W - HDR_W;
    localparam int CNT_W   = 3;    // wide enough to count 0..MSG_BYTES-1

    localparam logic [7:0] HDR_MEM_PARAMS = 8'h01;
    localparam logic [7:0] HDR_SYS_STATUS = 8'h02;

    localparam logic [7:0] ACK_DEFAULT  = 8'hA5;
    localparam logic [7:0] NACK_DEFAULT = 8'h5A;

    // Field positions relative to the payload (packet bits [39:8]).
    localparam int NO_NUMS_LSB     = 0;
    localparam int TEST_MODE_BIT   = 8;
    localparam int RSVD_LSB        = 9;
    localparam int RSVD_MSB        = 15;
    localparam int PULSE_WIDTH_LSB = 16;
    localparam int PULSE_GAP_LSB   = 24;
    localparam int RUN_REQ_BIT     = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECODE  = 2'd2,
        ST_REPLY   = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] no_nums;
        logic       test_mode;
        logic [7:0] pulse_width;
        logic [7:0] pulse_gap;
    } cfg_t;

endpackage

// File: rtl/uart_msg_assembler.sv
// Byte assembler: shifts received bytes into a 40-bit packet, counts bytes, times inter-byte gaps.
// Ports: rx_data/rx_valid in, accept gates capture; msg/msg_valid out (msg_valid the cycle after byte 5),
// byte_cnt shows bytes held, timeout is a combinational strobe when a partial packet goes stale.
module uart_msg_assembler
    import uart_msg_pkg::*;
#(
    parameter int unsigned GAP_MAX = 24_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             accept,
    output logic [MSG_W-1:0] msg,
    output logic             msg_valid,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             timeout
);

    localparam int GAP_W = $clog2(GAP_MAX + 1);

    logic [GAP_W-1:0] gap;
    logic             collecting;
    logic             take;

    assign collecting = (byte_cnt != '0);
    assign take       = accept && rx_valid;
    // A byte arriving on the very cycle the budget is used up still counts.
    assign timeout    = collecting && !rx_valid && (gap == GAP_W'(GAP_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg       <= '0;
            msg_valid <= 1'b0;
            byte_cnt  <= '0;
            gap       <= '0;
        end else begin
            msg_valid <= 1'b0;
            if (take) begin
                // New bytes enter at the top so the first byte ends up in [7:0].
                msg <= {rx_data, msg[MSG_W-1:8]};
                gap <= '0;
                if (byte_cnt == CNT_W'(MSG_BYTES - 1)) begin
                    byte_cnt  <= '0;
                    msg_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end else if (timeout) begin
                byte_cnt <= '0;
                gap      <= '0;
            end else if (collecting && gap != GAP_W'(GAP_MAX)) begin
                gap <= gap + GAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_msg_ctrl.sv
// UART message controller: assembles 5-byte packets, decodes MEM_PARAMS / SYS_STATUS, replies ACK/NACK.
// Ports: rx_* byte stream in; tx_* reply out (valid/ready); cfg_* + cfg_valid configure the memory
// manager; run enables it, mem_done stops it; err is sticky; led0/led1 mirror run/err.
module uart_msg_ctrl
    import uart_msg_pkg::*;
#(
    parameter int unsigned CLK_RATE     = 12_000_000,
    parameter int unsigned TIMEOUT_CLKS = 24_000,
    parameter logic [7:0]  ACK_BYTE     = ACK_DEFAULT,
    parameter logic [7:0]  NACK_BYTE    = NACK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       mem_done,
    output logic [7:0] cfg_no_nums,
    output logic       cfg_test_mode,
    output logic [7:0] cfg_pulse_width,
    output logic [7:0] cfg_pulse_gap,
    output logic       cfg_valid,
    output logic       run,
    output logic       err,
    output logic       led0,
    output logic       led1
);

    // A gap budget longer than one second of clock is meaningless for a byte stream.
    localparam int unsigned GAP_MAX = (TIMEOUT_CLKS < CLK_RATE) ? TIMEOUT_CLKS : CLK_RATE;

    state_t state_q, state_d;

    logic [MSG_W-1:0] msg;
    logic             msg_valid;
    logic [CNT_W-1:0] byte_cnt;
    logic             timeout;
    logic             accept;

    logic [HDR_W-1:0] header;
    logic [PL_W-1:0]  payload;
    logic             unused_reserved;

    logic cfg_load, err_set, err_clr, run_load, run_val, reply_load, reply_ack;

    assign accept  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign header  = msg[HDR_W-1:0];
    assign payload = msg[MSG_W-1:HDR_W];
    // Reserved MEM_PARAMS bits carry no meaning and are deliberately ignored.
    assign unused_reserved = ^payload[RSVD_MSB:RSVD_LSB];

    uart_msg_assembler #(
        .GAP_MAX (GAP_MAX)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .accept    (accept),
        .msg       (msg),
        .msg_valid (msg_valid),
        .byte_cnt  (byte_cnt),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_load   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        run_load   = 1'b0;
        run_val    = 1'b0;
        reply_load = 1'b0;
        reply_ack  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (timeout) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else if (rx_valid && byte_cnt == CNT_W'(MSG_BYTES - 1)) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Bytes cannot be taken while a packet is being processed.
                if (rx_valid) err_set = 1'b1;
                if (msg_valid) begin
                    state_d    = ST_REPLY;
                    reply_load = 1'b1;
                    if (header == HDR_MEM_PARAMS) begin
                        // Reconfiguring under a running memory manager is refused.
                        if (run) begin
                            err_set = 1'b1;
                        end else begin
                            cfg_load  = 1'b1;
                            reply_ack = 1'b1;
                        end
                    end else if (header == HDR_SYS_STATUS) begin
                        run_load = 1'b1;
                        if (payload[RUN_REQ_BIT] && cfg_no_nums == 8'd0) begin
                            // Nothing to run: keep run low and refuse.
                            err_set = 1'b1;
                        end else begin
                            run_val   = payload[RUN_REQ_BIT];
                            reply_ack = 1'b1;
                            if (!payload[RUN_REQ_BIT]) err_clr = 1'b1;
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REPLY: begin
                if (rx_valid) err_set = 1'b1;
                if (tx_valid && tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_no_nums     <= '0;
            cfg_test_mode   <= 1'b0;
            cfg_pulse_width <= '0;
            cfg_pulse_gap   <= '0;
            cfg_valid       <= 1'b0;
            run             <= 1'b0;
            err             <= 1'b0;
            tx_valid        <= 1'b0;
            tx_data         <= '0;
        end else begin
            cfg_valid <= cfg_load;
            if (cfg_load) begin
                cfg_no_nums     <= payload[NO_NUMS_LSB +: 8];
                cfg_test_mode   <= payload[TEST_MODE_BIT];
                cfg_pulse_width <= payload[PULSE_WIDTH_LSB +: 8];
                cfg_pulse_gap   <= payload[PULSE_GAP_LSB +: 8];
            end
            // A decoded SYS_STATUS overrides a simultaneous mem_done.
            if (run_load) begin
                run <= run_val;
            end else if (mem_done) begin
                run <= 1'b0;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (reply_load) begin
                tx_valid <= 1'b1;
                tx_data  <= reply_ack ? ACK_BYTE : NACK_BYTE;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

    assign led0 = run;
    assign led1 = err;

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Self-checking bench for uart_msg_ctrl: directed scenarios followed by randomized packets,
// compared against a packet-level reference model of the controller.
// Drives inputs 1 time unit after the rising edge and samples there as well.
module tb_uart_msg_ctrl;
    import uart_msg_pkg::*;

    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       mem_done;
    logic [7:0] cfg_no_nums;
    logic       cfg_test_mode;
    logic [7:0] cfg_pulse_width;
    logic [7:0] cfg_pulse_gap;
    logic       cfg_valid;
    logic       run;
    logic       err;
    logic       led0;
    logic       led1;

    int checks = 0;
    int errors = 0;
    int cfg_pulses = 0;
    int xfers = 0;

    // Reference model state.
    logic       m_run, m_err, m_tm;
    logic [7:0] m_nn, m_pw, m_pg;

    uart_msg_ctrl #(
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .mem_done        (mem_done),
        .cfg_no_nums     (cfg_no_nums),
        .cfg_test_mode   (cfg_test_mode),
        .cfg_pulse_width (cfg_pulse_width),
        .cfg_pulse_gap   (cfg_pulse_gap),
        .cfg_valid       (cfg_valid),
        .run             (run),
        .err             (err),
        .led0            (led0),
        .led1            (led1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_valid) cfg_pulses++;
        if (tx_valid && tx_ready) xfers++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_err = 1'b0; m_tm = 1'b0;
        m_nn = 8'd0; m_pw = 8'd0; m_pg = 8'd0;
    endtask

    // Packet-level rules: what reply, and whether a configuration update is expected.
    task automatic model_apply(input logic [7:0] hdr, input logic [31:0] pl,
                               output logic [7:0] rep, output int pulse);
        pulse = 0;
        rep   = NACK_DEFAULT;
        if (hdr == HDR_MEM_PARAMS) begin
            if (m_run) begin
                m_err = 1'b1;
            end else begin
                m_nn = pl[7:0]; m_tm = pl[8]; m_pw = pl[23:16]; m_pg = pl[31:24];
                pulse = 1;
                rep = ACK_DEFAULT;
            end
        end else if (hdr == HDR_SYS_STATUS) begin
            if (pl[0] && m_nn == 8'd0) begin
                m_run = 1'b0;
                m_err = 1'b1;
            end else begin
                m_run = pl[0];
                if (!pl[0]) m_err = 1'b0;
                rep = ACK_DEFAULT;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_txv"}, tx_valid, 0);
        check({tag, "_txd"}, tx_data, 0);
        check({tag, "_cfg"}, {cfg_no_nums, cfg_test_mode, cfg_pulse_width, cfg_pulse_gap}, 0);
        check({tag, "_cfgv"}, cfg_valid, 0);
        check({tag, "_run_err"}, {run, err, led0, led1}, 0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cfg"}, {cfg_no_nums, cfg_test_mode, cfg_pulse_width, cfg_pulse_gap},
              {m_nn, m_tm, m_pw, m_pg});
        check({tag, "_run"}, {run, led0}, {m_run, m_run});
        check({tag, "_err"}, {err, led1}, {m_err, m_err});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [31:0] pl);
        logic [39:0] p;
        p = {pl, hdr};
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (i > 0) repeat ($urandom_range(0, 3)) step();
            send_byte(p[8*i +: 8]);
        end
    endtask

    task automatic get_reply(input logic [7:0] exp, input int hold, input bit inject);
        int n;
        logic [7:0] d0;
        bit stable;
        n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        check("reply_valid", tx_valid, 1);
        d0 = tx_data;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            rx_data  = 8'h33;
            rx_valid = inject && (i == hold / 2);
            step();
            if (tx_valid !== 1'b1 || tx_data !== d0) stable = 1'b0;
        end
        rx_valid = 1'b0;
        if (hold > 0) check("reply_stable", stable, 1);
        check("reply_data", tx_data, exp);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("reply_done", tx_valid, 0);
    endtask

    task automatic do_pkt(input string tag, input logic [7:0] hdr, input logic [31:0] pl,
                          input int hold, input bit inject);
        logic [7:0] rep;
        int pulse, p0, x0;
        model_apply(hdr, pl, rep, pulse);
        p0 = cfg_pulses;
        x0 = xfers;
        send_pkt(hdr, pl);
        get_reply(rep, hold, inject);
        if (inject) m_err = 1'b1;
        check({tag, "_pulses"}, cfg_pulses - p0, pulse);
        check({tag, "_xfers"}, xfers - x0, 1);
        check_state(tag);
    endtask

    task automatic mem_pulse();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        m_run = 1'b0;
        check("mem_done_run", run, 0);
    endtask

    initial begin
        logic [31:0] pl;
        logic [7:0]  hdr;
        int          any_tx, x0, sel;

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; mem_done = 1'b0;
        model_reset();
        #1;
        check_outputs_reset("reset");
        repeat (3) step();
        rst = 1'b0;
        step();
        check_outputs_reset("post_reset");

        // Basic configuration.
        do_pkt("mem_basic", HDR_MEM_PARAMS, {8'd12, 8'd12, 8'h00, 8'd5}, 0, 0);
        check("cfg_basic_values", {cfg_no_nums, cfg_test_mode, cfg_pulse_width, cfg_pulse_gap},
              {8'd5, 1'b0, 8'd12, 8'd12});

        // Start, stop via mem_done, start again.
        do_pkt("sys_run1", HDR_SYS_STATUS, 32'h0000_0001, 0, 0);
        check("run_on", {run, led0}, 2'b11);
        mem_pulse();
        do_pkt("sys_run1b", HDR_SYS_STATUS, {$urandom, 1'b1} >> 0 | 32'h1, 0, 0);

        // Reconfigure while running: refused.
        do_pkt("mem_busy", HDR_MEM_PARAMS, $urandom, 0, 0);
        check("busy_err", err, 1);

        // Unknown header, then clear the error.
        do_pkt("unknown", 8'h7F, $urandom, 0, 0);
        do_pkt("sys_clear", HDR_SYS_STATUS, $urandom & 32'hFFFF_FFFE, 0, 0);
        check("err_cleared", {err, run}, 2'b00);

        // Partial packet that goes stale.
        x0 = xfers;
        any_tx = 0;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        for (int i = 0; i < TO + 5; i++) begin
            step();
            if (tx_valid) any_tx = 1;
        end
        m_err = 1'b1;
        check("timeout_no_reply", any_tx, 0);
        check("timeout_err", err, 1);
        check("timeout_xfers", xfers - x0, 0);
        do_pkt("after_timeout", HDR_MEM_PARAMS, {8'd3, 8'd4, 8'h01, 8'd9}, 0, 0);

        // Long stall on the reply with a stray byte injected.
        do_pkt("hold_reply", HDR_MEM_PARAMS, $urandom, 100, 1);
        check("hold_err", err, 1);

        // Randomized traffic.
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 3);
            pl  = $urandom;
            if (sel == 0) begin
                hdr = HDR_MEM_PARAMS;
                if ($urandom_range(0, 3) == 0) pl[7:0] = 8'd0;
            end else if (sel == 3) begin
                hdr = 8'($urandom_range(3, 255));
            end else begin
                hdr = HDR_SYS_STATUS;
            end
            do_pkt("rand", hdr, pl, $urandom_range(0, 4), 0);
            if ($urandom_range(0, 3) == 0) mem_pulse();
        end

        // Reset in the middle of a packet.
        send_byte(HDR_MEM_PARAMS);
        send_byte(8'hEE);
        rst = 1'b1;
        #1;
        check_outputs_reset("mid_pkt_rst");
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        step();
        // No configuration yet, so a run request is refused.
        do_pkt("run_no_nums", HDR_SYS_STATUS, 32'h0000_0001, 0, 0);
        check("run_no_nums_run", run, 0);
        do_pkt("post_rst_mem", HDR_MEM_PARAMS, {8'd7, 8'd8, 8'h01, 8'd2}, 0, 0);

        // Reset in the middle of a reply.
        send_pkt(HDR_SYS_STATUS, 32'h0000_0000);
        step();
        step();
        check("pre_rst_reply", tx_valid, 1);
        rst = 1'b1;
        #1;
        check_outputs_reset("mid_reply_rst");
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        step();
        do_pkt("final", HDR_SYS_STATUS, 32'h0000_0000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
